// File: rtl/pin_entry_if.sv
// Keypad-to-PIN-controller bundle: key strobe, provisioned PIN, and the controller's status outputs.
interface pin_entry_if #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned PW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);

  logic          key_valid;
  logic [3:0]    key_value;
  logic [PW-1:0] ref_pin;
  logic [PW-1:0] entered_pin;
  logic [CW-1:0] digit_count;
  logic          pin_ready;
  logic          pin_match;
  logic          entry_error;
  logic          timeout;
  logic          locked;
  logic [FW-1:0] fail_count;

  modport master (
    output key_valid, key_value, ref_pin,
    input  entered_pin, digit_count, pin_ready, pin_match, entry_error, timeout, locked, fail_count
  );

  modport slave (
    input  key_valid, key_value, ref_pin,
    output entered_pin, digit_count, pin_ready, pin_match, entry_error, timeout, locked, fail_count
  );
endinterface

// File: rtl/pin_entry_ctrl.sv
// Keypad PIN entry controller: digit buffer with backspace/clear/submit, inter-key timeout,
// PIN comparison, consecutive-failure counting and timed lockout.
module pin_entry_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned AUTO_SUBMIT = 0,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYC    = 5000
) (
  input  logic       clk,
  input  logic       reset,
  pin_entry_if.slave bus
);
  localparam int unsigned PW   = 4 * DIGITS;
  localparam int unsigned CW   = $clog2(DIGITS + 1);
  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [3:0] KEY_BS  = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_ENT = 4'hE;

  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKED} state_t;

  state_t        state, state_d;
  logic [PW-1:0] pin_q, pin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic          locked_q, locked_d;
  logic          ready_q, ready_d;
  logic          match_q, match_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          is_digit, is_cmd, key_ok;

  // Only listed codes in IDLE/ENTRY count as accepted keys
  assign is_digit = (bus.key_value <= 4'd9);
  assign is_cmd   = (bus.key_value == KEY_BS) || (bus.key_value == KEY_CLR) ||
                    (bus.key_value == KEY_ENT);
  assign key_ok   = bus.key_valid && (is_digit || is_cmd) && (state == IDLE || state == ENTRY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    pin_d    = pin_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    locked_d = locked_q;
    ready_d  = 1'b0;
    match_d  = 1'b0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    fail_inc = fail_q + FW'(1);

    unique case (state)
      IDLE, ENTRY: begin
        if (key_ok) begin
          timer_d = TW'(TIMEOUT_CYC);
          if (is_digit) begin
            if (cnt_q < CW'(DIGITS)) begin
              pin_d   = PW'({pin_q, bus.key_value});
              cnt_d   = cnt_q + CW'(1);
              state_d = (AUTO_SUBMIT != 0 && cnt_q == CW'(DIGITS - 1)) ? CHECK : ENTRY;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.key_value == KEY_BS) begin
            if (cnt_q != '0) begin
              pin_d = pin_q >> 4;
              cnt_d = cnt_q - CW'(1);
              if (cnt_q == CW'(1)) state_d = IDLE;
            end
          end else if (bus.key_value == KEY_CLR) begin
            pin_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == CW'(DIGITS)) begin
            state_d = CHECK;
          end else begin
            err_d   = 1'b1;
            pin_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (state == ENTRY && TIMEOUT_CYC != 0) begin
          // Accepted keys take priority over expiry, handled by the branch above
          if (timer_q <= TW'(1)) begin
            pin_d   = '0;
            cnt_d   = '0;
            tmo_d   = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      CHECK: begin
        ready_d = 1'b1;
        match_d = (pin_q == bus.ref_pin);
        pin_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
        if (match_d) begin
          fail_d = '0;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_d = LOCKED;
            timer_d = TW'(LOCK_CYC);
          end
        end
      end
      LOCKED: begin
        // First LOCKED cycle only raises locked; the window then runs LOCK_CYC cycles
        if (!locked_q) begin
          locked_d = 1'b1;
        end else if (timer_q <= TW'(1)) begin
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pin_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      pin_q    <= pin_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      match_q  <= match_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.entered_pin = pin_q;
  assign bus.digit_count = cnt_q;
  assign bus.fail_count  = fail_q;
  assign bus.locked      = locked_q;
  assign bus.pin_ready   = ready_q;
  assign bus.pin_match   = match_q;
  assign bus.entry_error = err_q;
  assign bus.timeout     = tmo_q;
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Scoreboard bench for pin_entry_ctrl: a manual-submit and an auto-submit instance.
module tb_pin_entry_ctrl;
  localparam logic [2:0] K_RDY = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_TMO = 3'b001;

  typedef struct {
    int         id;
    logic [2:0] kind;
    logic       match;
    logic [1:0] fc;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pin_entry_if #(.DIGITS(4), .MAX_FAILS(3)) bus0 ();
  pin_entry_if #(.DIGITS(4), .MAX_FAILS(3)) bus1 ();

  pin_entry_ctrl #(.DIGITS(4), .AUTO_SUBMIT(0), .TIMEOUT_CYC(20), .MAX_FAILS(3), .LOCK_CYC(16))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  pin_entry_ctrl #(.DIGITS(4), .AUTO_SUBMIT(1), .TIMEOUT_CYC(20), .MAX_FAILS(3), .LOCK_CYC(16))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int d, input logic [2:0] k, input logic m,
                           input logic [1:0] f, input int dly);
    exp_t e;
    e.id = d; e.kind = k; e.match = m; e.fc = f; e.at = cyc + dly;
    sb.push_back(e);
  endtask

  // Drives one key strobe at the current falling edge; returns one cycle later
  task automatic press(input int d, input logic [3:0] v);
    if (d == 0) begin bus0.key_valid = 1'b1; bus0.key_value = v; end
    else        begin bus1.key_valid = 1'b1; bus1.key_value = v; end
    @(negedge clk);
    bus0.key_valid = 1'b0;
    bus1.key_valid = 1'b0;
  endtask

  task automatic enter4(input int d, input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(d, code[4*i +: 4]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every status pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] p;
        logic       m;
        logic [1:0] f;
        exp_t       e;
        p = (d == 0) ? {bus0.pin_ready, bus0.entry_error, bus0.timeout}
                     : {bus1.pin_ready, bus1.entry_error, bus1.timeout};
        m = (d == 0) ? bus0.pin_match : bus1.pin_match;
        f = (d == 0) ? bus0.fail_count : bus1.fail_count;
        if (!p[2]) chk("match_without_ready", 32'(m), 32'd0);
        if (p != 3'b000) begin
          if (sb.size() == 0 || sb[0].id != d) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse dut%0d: got %b required none (cycle %0d)", d, p, cyc);
          end else begin
            e = sb.pop_front();
            chk("pulse_kind", 32'(p), 32'(e.kind));
            chk("pulse_cycle", cyc, e.at);
            if (e.kind == K_RDY) begin
              chk("pin_match", 32'(m), 32'(e.match));
              chk("fail_at_ready", 32'(f), 32'(e.fc));
            end
          end
        end
      end
      if (sb.size() > 0 && sb[0].at < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_pulse dut%0d: got none required %b at cycle %0d", sb[0].id, sb[0].kind, sb[0].at);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus0.key_valid = 1'b0; bus0.key_value = 4'h0; bus0.ref_pin = 16'h1234;
    bus1.key_valid = 1'b0; bus1.key_value = 4'h0; bus1.ref_pin = 16'h1234;
    idle(2);
    chk("rst_entered", 32'(bus0.entered_pin), 32'h0);
    chk("rst_count", 32'(bus0.digit_count), 32'd0);
    chk("rst_fail", 32'(bus0.fail_count), 32'd0);
    chk("rst_locked", 32'(bus0.locked), 32'd0);
    chk("rst_ready", 32'(bus0.pin_ready), 32'd0);
    chk("rst_auto_count", 32'(bus1.digit_count), 32'd0);
    reset = 1'b0;
    idle(1);

    // Correct PIN with explicit enter
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3); press(0, 4'h4);
    chk("buf_1234", 32'(bus0.entered_pin), 32'h1234);
    chk("count_full", 32'(bus0.digit_count), 32'd4);
    expect_ev(0, K_RDY, 1'b1, 2'd0, 2);
    press(0, 4'hE);
    idle(2);
    chk("count_after_ok", 32'(bus0.digit_count), 32'd0);
    chk("buf_after_ok", 32'(bus0.entered_pin), 32'h0);
    chk("fail_after_ok", 32'(bus0.fail_count), 32'd0);

    // Backspace mid-entry
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h9);
    chk("buf_0129", 32'(bus0.entered_pin), 32'h0129);
    press(0, 4'hA);
    chk("buf_bs", 32'(bus0.entered_pin), 32'h0012);
    chk("count_bs", 32'(bus0.digit_count), 32'd2);
    press(0, 4'h3); press(0, 4'h4);
    chk("buf_bs_1234", 32'(bus0.entered_pin), 32'h1234);
    expect_ev(0, K_RDY, 1'b1, 2'd0, 2);
    press(0, 4'hE);
    idle(2);

    // Digit into a full buffer, then short submit
    enter4(0, 16'h1234);
    expect_ev(0, K_ERR, 1'b0, 2'd0, 1);
    press(0, 4'h5);
    chk("buf_full_kept", 32'(bus0.entered_pin), 32'h1234);
    chk("count_full_kept", 32'(bus0.digit_count), 32'd4);
    press(0, 4'hC);
    chk("clear_count", 32'(bus0.digit_count), 32'd0);
    chk("clear_buf", 32'(bus0.entered_pin), 32'h0);
    press(0, 4'h1); press(0, 4'h2);
    expect_ev(0, K_ERR, 1'b0, 2'd0, 1);
    press(0, 4'hE);
    chk("short_buf", 32'(bus0.entered_pin), 32'h0);
    chk("short_count", 32'(bus0.digit_count), 32'd0);
    idle(3);

    // One mismatch so the timeout can be shown not to disturb fail_count
    enter4(0, 16'h0000);
    expect_ev(0, K_RDY, 1'b0, 2'd1, 2);
    press(0, 4'hE);
    idle(2);
    chk("fail_one", 32'(bus0.fail_count), 32'd1);

    // Inter-key timeout after 20 idle cycles
    expect_ev(0, K_TMO, 1'b0, 2'd0, 21);
    press(0, 4'h7);
    idle(20);
    chk("tmo_count", 32'(bus0.digit_count), 32'd0);
    chk("tmo_buf", 32'(bus0.entered_pin), 32'h0);
    chk("tmo_fail_kept", 32'(bus0.fail_count), 32'd1);
    idle(1);

    // Key landing on the expiry cycle wins
    press(0, 4'h7);
    idle(19);
    press(0, 4'h8);
    chk("expiry_key_buf", 32'(bus0.entered_pin), 32'h0078);
    chk("expiry_key_count", 32'(bus0.digit_count), 32'd2);
    press(0, 4'hC);
    idle(2);

    // A match resets the failure count
    enter4(0, 16'h1234);
    expect_ev(0, K_RDY, 1'b1, 2'd0, 2);
    press(0, 4'hE);
    idle(2);
    chk("fail_cleared", 32'(bus0.fail_count), 32'd0);

    // Three mismatches -> lockout
    for (int k = 1; k <= 3; k++) begin
      enter4(0, 16'h0000);
      expect_ev(0, K_RDY, 1'b0, 2'(k), 2);
      press(0, 4'hE);
      idle(1);
      chk("fail_step", 32'(bus0.fail_count), 32'(k));
      if (k < 3) idle(1);
    end
    chk("locked_on_ready_cycle", 32'(bus0.locked), 32'd0);
    for (int i = 0; i < 16; i++) begin
      press(0, (i % 5 == 4) ? 4'hE : 4'(i % 10));
      chk("locked_window", 32'(bus0.locked), 32'd1);
      chk("locked_ignores_keys", 32'(bus0.digit_count), 32'd0);
    end
    idle(1);
    chk("unlock", 32'(bus0.locked), 32'd0);
    chk("unlock_fail", 32'(bus0.fail_count), 32'd0);
    chk("unlock_count", 32'(bus0.digit_count), 32'd0);

    // Auto-submit on the fourth digit
    press(1, 4'h1); press(1, 4'h2); press(1, 4'h3);
    expect_ev(1, K_RDY, 1'b1, 2'd0, 2);
    press(1, 4'h4);
    chk("auto_buf", 32'(bus1.entered_pin), 32'h1234);
    idle(2);
    chk("auto_count_after", 32'(bus1.digit_count), 32'd0);

    // Reset during lockout
    for (int k = 1; k <= 3; k++) begin
      enter4(0, 16'h0000);
      expect_ev(0, K_RDY, 1'b0, 2'(k), 2);
      press(0, 4'hE);
      idle(2);
    end
    idle(2);
    chk("relock", 32'(bus0.locked), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_lock_locked", 32'(bus0.locked), 32'd0);
    chk("rst_lock_fail", 32'(bus0.fail_count), 32'd0);
    chk("rst_lock_ready", 32'(bus0.pin_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Reset mid-entry
    press(0, 4'h5); press(0, 4'h6);
    chk("mid_count", 32'(bus0.digit_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_buf", 32'(bus0.entered_pin), 32'h0);
    chk("rst_mid_count", 32'(bus0.digit_count), 32'd0);
    chk("rst_mid_pulses", 32'({bus0.pin_ready, bus0.pin_match, bus0.entry_error, bus0.timeout}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
